fdiv_ctrl: RTL and testbench

FDIV_CTRL -- requirements
Module: fdiv_ctrl

---
 rtl/fdiv_pkg.sv | 14 +
 rtl/fdiv_cnt.sv | 29 ++
 rtl/fdiv_ctrl.sv | 100 ++++++++++
 tb/tb_fdiv_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and default widths for the clock-enable divider controller.
// No logic; imported by fdiv_ctrl and fdiv_cnt.
package fdiv_pkg;

  localparam int W_DIV_DEF = 4;
  localparam int W_CNT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fdiv_cnt.sv
// Prescale counter 0..div-1 with sync clear and enable; tc is decoded from registers.
// Zero latency on tc; no backpressure, the count advances on every enabled edge.
module fdiv_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tc
);

  logic [W-1:0] pcnt;

  // div is held at 1 or more by the controller, so div-1 never wraps.
  assign tc = (pcnt == div - W'(1));

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tc ? '0 : pcnt + W'(1);
    end
  end

endmodule

// File: rtl/fdiv_ctrl.sv
// Burst clock-enable generator: tick every div cycles while running, done after cnt ticks.
// Config handshake accepted only in IDLE; outputs are register decodes, no backpressure on tick.
module fdiv_ctrl
  import fdiv_pkg::*;
#(
  parameter int W_DIV = W_DIV_DEF,
  parameter int W_CNT = W_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  input  logic [W_DIV-1:0] cfg_div,
  input  logic [W_CNT-1:0] cfg_cnt,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [W_DIV-1:0] div_q;
  logic [W_DIV-1:0] cfg_div_eff;
  logic [W_CNT-1:0] burst_q;
  logic [W_CNT-1:0] rem_q;
  logic             cfg_acc;
  logic             run_go;
  logic             tc;
  logic             cnt_tick;
  logic             last_tick;

  assign cfg_rdy     = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign tick        = (state == RUN) && tc;

  assign cfg_acc     = cfg_vld && cfg_rdy;
  assign cfg_div_eff = (cfg_div == '0) ? W_DIV'(1) : cfg_div;
  assign run_go      = (state == IDLE) && start && !stop;

  // A tick coinciding with stop is emitted but does not count toward the burst.
  assign cnt_tick    = tick && !stop && (burst_q != '0);
  assign last_tick   = cnt_tick && (rem_q == W_CNT'(1));

  fdiv_cnt #(
    .W (W_DIV)
  ) u_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   ((state != RUN) || stop),
    .en    (state == RUN),
    .div   (div_q),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (run_go) state_nxt = RUN;
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (last_tick) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      div_q   <= W_DIV'(1);
      burst_q <= '0;
      rem_q   <= '0;
    end else begin
      if (cfg_acc) begin
        div_q   <= cfg_div_eff;
        burst_q <= cfg_cnt;
      end
      // A config offered alongside start is the one this run uses.
      if (run_go) begin
        rem_q <= cfg_acc ? cfg_cnt : burst_q;
      end else if (cnt_tick && (rem_q != '0)) begin
        rem_q <= rem_q - W_CNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl: hand-computed tick/done/busy timelines per scenario.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_fdiv_ctrl;

  logic       clk;
  logic       rst_b;
  logic       cfg_vld;
  logic       cfg_rdy;
  logic [3:0] cfg_div;
  logic [7:0] cfg_cnt;
  logic       start;
  logic       stop;
  logic       tick;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  fdiv_ctrl #(
    .W_DIV (4),
    .W_CNT (8)
  ) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .cfg_vld (cfg_vld),
    .cfg_rdy (cfg_rdy),
    .cfg_div (cfg_div),
    .cfg_cnt (cfg_cnt),
    .start   (start),
    .stop    (stop),
    .tick    (tick),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a config together with start, then land in RUN cycle 1.
  task automatic launch(input logic [3:0] d, input logic [7:0] c);
    cfg_vld = 1'b1;
    cfg_div = d;
    cfg_cnt = c;
    start   = 1'b1;
    step();
    cfg_vld = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    rst_b   = 1'b0;
    cfg_vld = 1'b0;
    cfg_div = '0;
    cfg_cnt = '0;
    start   = 1'b0;
    stop    = 1'b0;
    step();
    step();
    rst_b = 1'b1;
    chk("rst_tick", tick, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_rdy", cfg_rdy, 1'b1);

    // div=5, burst=3: ticks in RUN cycles 5, 10, 15; done in cycle 16
    launch(4'd5, 8'd3);
    for (int c = 1; c <= 15; c++) begin
      chk($sformatf("b3_tick_c%0d", c), tick, (c % 5 == 0));
      chk($sformatf("b3_done_c%0d", c), done, 1'b0);
      if (c < 15) step();
    end
    step();
    chk("b3_done_pulse", done, 1'b1);
    chk("b3_done_tick", tick, 1'b0);
    chk("b3_done_busy", busy, 1'b1);
    step();
    chk("b3_idle_done", done, 1'b0);
    chk("b3_idle_busy", busy, 1'b0);
    chk("b3_idle_rdy", cfg_rdy, 1'b1);

    // div=0 treated as 1, continuous; stop at cycle 7
    launch(4'd0, 8'd0);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("d1_tick_c%0d", c), tick, 1'b1);
      if (c == 7) stop = 1'b1;
      else step();
    end
    step();
    stop = 1'b0;
    chk("d1_stop_busy", busy, 1'b0);
    chk("d1_stop_done", done, 1'b0);
    chk("d1_stop_tick", tick, 1'b0);

    // div=4 continuous, stop coinciding with the first tick
    launch(4'd4, 8'd0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("d4_tick_c%0d", c), tick, (c == 4));
      if (c == 4) stop = 1'b1;
      else step();
    end
    step();
    stop = 1'b0;
    chk("d4_stop_busy", busy, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("d4_after_tick_%0d", c), tick, 1'b0);
      chk($sformatf("d4_after_done_%0d", c), done, 1'b0);
      step();
    end

    // div=3 run; a div=2 offer during RUN must be ignored
    launch(4'd3, 8'd0);
    cfg_vld = 1'b1;
    cfg_div = 4'd2;
    cfg_cnt = 8'd1;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("ign_rdy_c%0d", c), cfg_rdy, 1'b0);
      chk($sformatf("ign_tick_c%0d", c), tick, (c % 3 == 0));
      if (c == 9) stop = 1'b1;
      else step();
    end
    step();
    stop    = 1'b0;
    cfg_vld = 1'b0;
    chk("ign_stop_busy", busy, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("ign_rerun_tick_c%0d", c), tick, (c % 3 == 0));
      chk($sformatf("ign_rerun_busy_c%0d", c), busy, 1'b1);
      if (c == 6) stop = 1'b1;
      else step();
    end
    step();
    stop = 1'b0;

    // reset mid-burst aborts without done and restores div=1, burst=0
    launch(4'd5, 8'd3);
    for (int c = 1; c <= 7; c++) step();
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_tick", tick, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_rdy", cfg_rdy, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("mrst_run_tick_c%0d", c), tick, 1'b1);
      chk($sformatf("mrst_run_done_c%0d", c), done, 1'b0);
      if (c == 4) stop = 1'b1;
      else step();
    end
    step();
    stop = 1'b0;
    chk("mrst_stop_busy", busy, 1'b0);

    // start and stop together in IDLE are a no-op
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", busy, 1'b0);
    chk("ss_rdy", cfg_rdy, 1'b1);
    step();
    chk("ss_busy_late", busy, 1'b0);
    chk("ss_tick_late", tick, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
